// File: rtl/pnr_trigger_sequencer.sv
// ---------------------------------------------------------------------------
// pnr_trigger_sequencer
//
// Turns an asynchronous detector trigger into the strobe sequence that the
// photon-number-resolving comparator core needs. For each accepted trigger:
//   clear strobe -> programmable delay -> latch strobe -> two settle cycles
//   (result_valid_o on the second) -> programmable holdoff -> idle again.
// It also keeps saturating counts of accepted and missed triggers.
//
// Ports
//   ADC_CLK         ADC sample clock, the only clock
//   rstn_i          asynchronous active-low reset
//   enable_i        arms the sequencer (level)
//   ext_trig_i      external trigger, asynchronous to ADC_CLK
//   delay_i         cycles from clear strobe to latch strobe (0 acts as 1)
//   holdoff_i       dead cycles after the settle window
//   cnt_clr_i       synchronous clear of both statistics counters
//   clear_o         one-cycle clear strobe to the PNR core
//   latch_o         one-cycle latch strobe to the PNR core
//   result_valid_o  one-cycle pulse two cycles after latch_o
//   busy_o          high whenever the FSM is not idle
//   state_o         raw FSM state for debug readout
//   trig_cnt_o      accepted-trigger count (saturating)
//   miss_cnt_o      rejected-trigger count (saturating)
//
// Every output is either a register or a decode of registered state, so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module pnr_trigger_sequencer #(
  parameter int DLY_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             ADC_CLK,
  input  logic             rstn_i,
  input  logic             enable_i,
  input  logic             ext_trig_i,
  input  logic [DLY_W-1:0] delay_i,
  input  logic [DLY_W-1:0] holdoff_i,
  input  logic             cnt_clr_i,
  output logic             clear_o,
  output logic             latch_o,
  output logic             result_valid_o,
  output logic             busy_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] trig_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  // Encoding is visible on state_o, so the values are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4,
    ST_POST  = 3'd5
  } state_t;

  localparam logic [DLY_W-1:0] DLY_ONE = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DLY_W-1:0] hold_q, hold_d;
  logic [DLY_W-1:0] dly_eff;

  logic sync1_q, sync2_q, prev_q, rise_q;
  logic accept;
  logic trig_evt, miss_evt;

  logic [CNT_W-1:0] trig_cnt_q, miss_cnt_q;

  // Trigger front end: two metastability flops, then an edge detector whose
  // result is registered so the FSM only ever sees a clean one-cycle event.
  // A trigger held high therefore produces a single event.
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= ext_trig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  // State, shared down-counter and the shadowed configuration. delay_i and
  // holdoff_i are only captured when a trigger is accepted, so software can
  // rewrite them at any time without disturbing a sequence in flight.
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic. One counter serves the delay, settle and holdoff
  // windows since only one of them is ever active.
  //
  // Delay: latch_o must land exactly max(delay,1) cycles after clear_o.
  // CLEAR itself is one of those cycles, so WAIT lasts max(delay,1)-1
  // cycles; WAIT is skipped entirely when the effective delay is 1.
  //
  // Settle: POST runs for two cycles (counter 1 then 0), result_valid_o is
  // asserted on the second.
  //
  // Holdoff: HOLD lasts holdoff+1 cycles, so holdoff 0 still passes through
  // HOLD once.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    hold_d   = hold_q;
    accept   = 1'b0;
    dly_eff  = (dly_q == '0) ? DLY_ONE : dly_q;

    case (state_q)
      ST_IDLE: begin
        if (rise_q && enable_i) begin
          accept  = 1'b1;
          state_d = ST_CLEAR;
          dly_d   = delay_i;
          hold_d  = holdoff_i;
        end
      end

      ST_CLEAR: begin
        cnt_d = dly_eff - DLY_ONE;
        if (dly_eff == DLY_ONE) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - DLY_ONE;
        if (cnt_q <= DLY_ONE) begin
          state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        cnt_d   = DLY_ONE;
        state_d = ST_POST;
      end

      ST_POST: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - DLY_ONE;
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - DLY_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are pure decodes of the registered state, which makes them
  // mutually exclusive, one cycle wide, and forced low the instant reset
  // asserts.
  always_comb begin
    clear_o        = (state_q == ST_CLEAR);
    latch_o        = (state_q == ST_LATCH);
    result_valid_o = (state_q == ST_POST) && (cnt_q == '0);
    busy_o         = (state_q != ST_IDLE);
    state_o        = state_q;
  end

  // A trigger counts as accepted once its CLEAR cycle is issued. Any rise
  // the FSM does not take (disabled, or not idle) is a miss.
  assign trig_evt = (state_q == ST_CLEAR);
  assign miss_evt = rise_q & ~accept;

  // Statistics counters: saturate at all-ones, and a clear wins over an
  // increment arriving on the same edge.
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      trig_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      trig_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (trig_evt && (trig_cnt_q != '1)) begin
        trig_cnt_q <= trig_cnt_q + CNT_ONE;
      end
      if (miss_evt && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_ONE;
      end
    end
  end

  assign trig_cnt_o = trig_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_pnr_trigger_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pnr_trigger_sequencer
//
// Drives directed scenarios and then a randomized trigger stream into two
// copies of the sequencer: one at the default counter width and one with
// 3-bit counters so saturation is reached quickly. A cycle-indexed
// reference model predicts when each strobe appears and what the counters
// read; strobe predictions go into a scoreboard queue that an independent
// monitor drains as the DUT produces strobes.
// ---------------------------------------------------------------------------
module tb_pnr_trigger_sequencer;

  localparam int     DLY_W   = 16;
  localparam int     CNT_W   = 32;
  localparam int     SAT_W   = 3;
  localparam int     MAXC    = 8192;
  localparam longint SAT_MAX = (64'd1 << SAT_W) - 1;

  logic             ADC_CLK = 1'b0;
  logic             rstn_i;
  logic             enable_i;
  logic             ext_trig_i;
  logic [DLY_W-1:0] delay_i;
  logic [DLY_W-1:0] holdoff_i;
  logic             cnt_clr_i;

  logic             clear_o, latch_o, result_valid_o, busy_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] trig_cnt_o, miss_cnt_o;

  logic             sat_clear, sat_latch, sat_valid, sat_busy;
  logic [2:0]       sat_state;
  logic [SAT_W-1:0] sat_trig_cnt, sat_miss_cnt;

  pnr_trigger_sequencer #(.DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .ADC_CLK        (ADC_CLK),
    .rstn_i         (rstn_i),
    .enable_i       (enable_i),
    .ext_trig_i     (ext_trig_i),
    .delay_i        (delay_i),
    .holdoff_i      (holdoff_i),
    .cnt_clr_i      (cnt_clr_i),
    .clear_o        (clear_o),
    .latch_o        (latch_o),
    .result_valid_o (result_valid_o),
    .busy_o         (busy_o),
    .state_o        (state_o),
    .trig_cnt_o     (trig_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  pnr_trigger_sequencer #(.DLY_W(DLY_W), .CNT_W(SAT_W)) dut_sat (
    .ADC_CLK        (ADC_CLK),
    .rstn_i         (rstn_i),
    .enable_i       (enable_i),
    .ext_trig_i     (ext_trig_i),
    .delay_i        (delay_i),
    .holdoff_i      (holdoff_i),
    .cnt_clr_i      (cnt_clr_i),
    .clear_o        (sat_clear),
    .latch_o        (sat_latch),
    .result_valid_o (sat_valid),
    .busy_o         (sat_busy),
    .state_o        (sat_state),
    .trig_cnt_o     (sat_trig_cnt),
    .miss_cnt_o     (sat_miss_cnt)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  // Number of rising clock edges seen so far; edge N is the N-th posedge.
  int cyc = 0;
  always @(posedge ADC_CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Strobe codes are {result_valid, latch, clear}.
  typedef struct {
    int kind;
    int edge_no;
  } exp_t;
  exp_t sb_q[$];

  // Expected values holding during the cycle that follows each edge.
  bit     exp_busy [MAXC];
  longint exp_trig [MAXC];
  longint exp_miss [MAXC];

  // Reference model state.
  bit [3:0] hist;
  int       seq_idle;
  int       cur_clear;
  longint   trig_total;
  longint   miss_total;

  // Configuration currently presented to the DUT.
  bit en_v;
  int dly_v;
  int hld_v;

  function automatic longint satv(input longint v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic modelReset();
    hist       = 4'b0000;
    seq_idle   = -100;
    cur_clear  = -100;
    trig_total = 0;
    miss_total = 0;
  endtask

  // Presents one cycle of stimulus and advances the model to the edge that
  // will sample it. A trigger rise sampled on edge e reaches the sequencer's
  // decision on edge e+3. An accepted trigger clears on that edge, latches
  // max(delay,1) edges later, reports valid 2 edges after the latch, and is
  // idle again holdoff+4 edges after the latch.
  task automatic applyStimulus(input bit trig, input bit clr, input bit rst_v);
    int   e;
    int   d_eff;
    bit   arriving;
    exp_t item;
    @(negedge ADC_CLK);
    ext_trig_i = trig;
    cnt_clr_i  = clr;
    rstn_i     = rst_v;
    enable_i   = en_v;
    delay_i    = DLY_W'(dly_v);
    holdoff_i  = DLY_W'(hld_v);
    e = cyc + 1;
    if (e >= MAXC) begin
      errors++;
      $display("[TB] FAIL cycle_budget at edge %0d: got %0d, expected below %0d", cyc, e, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    if (!rst_v) begin
      modelReset();
      exp_busy[e] = 1'b0;
      exp_trig[e] = 0;
      exp_miss[e] = 0;
    end else begin
      arriving = hist[2] && !hist[3];
      hist     = {hist[2:0], trig};
      if (e == cur_clear + 1) trig_total++;
      if (arriving) begin
        if (en_v && (e > seq_idle)) begin
          d_eff     = (dly_v == 0) ? 1 : dly_v;
          cur_clear = e;
          seq_idle  = e + d_eff + hld_v + 4;
          item.kind = 1; item.edge_no = e;             sb_q.push_back(item);
          item.kind = 2; item.edge_no = e + d_eff;     sb_q.push_back(item);
          item.kind = 4; item.edge_no = e + d_eff + 2; sb_q.push_back(item);
        end else begin
          miss_total++;
        end
      end
      if (clr) begin
        trig_total = 0;
        miss_total = 0;
      end
      exp_busy[e] = (e >= cur_clear) && (e < seq_idle);
      exp_trig[e] = trig_total;
      exp_miss[e] = miss_total;
    end
    @(posedge ADC_CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic pulse(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b1);
  endtask

  task automatic clearCounters();
    applyStimulus(1'b0, 1'b1, 1'b1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_clear"}, clear_o, 0);
    checkOutput({tag, "_latch"}, latch_o, 0);
    checkOutput({tag, "_valid"}, result_valid_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_state"}, state_o, 0);
    checkOutput({tag, "_trig"}, trig_cnt_o, 0);
    checkOutput({tag, "_miss"}, miss_cnt_o, 0);
  endtask

  // Asserts reset shortly after an edge, checks that everything drops
  // without waiting for a clock, holds it across one edge, then releases.
  task automatic pulseReset();
    #2;
    rstn_i = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    sb_q.delete();
    exp_busy[cyc] = 1'b0;
    exp_trig[cyc] = 0;
    exp_miss[cyc] = 0;
    modelReset();
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle, compares both DUTs against the model. A strobe is
  // expected only when the head of the scoreboard is due on this edge.
  initial begin : monitor
    int main_code;
    int sat_code;
    int exp_code;
    forever begin
      @(negedge ADC_CLK);
      if (cyc < MAXC) begin
        main_code = int'({result_valid_o, latch_o, clear_o});
        sat_code  = int'({sat_valid, sat_latch, sat_clear});
        exp_code  = 0;
        if (sb_q.size() > 0 && sb_q[0].edge_no == cyc) begin
          exp_code = sb_q[0].kind;
          void'(sb_q.pop_front());
        end
        checkOutput("strobes", main_code, exp_code);
        checkOutput("sat_strobes", sat_code, exp_code);
        checkOutput("busy", busy_o, exp_busy[cyc]);
        checkOutput("sat_busy", sat_busy, exp_busy[cyc]);
        checkOutput("state_active", state_o != 3'd0, exp_busy[cyc]);
        checkOutput("sat_state_active", sat_state != 3'd0, exp_busy[cyc]);
        checkOutput("trig_cnt", trig_cnt_o, exp_trig[cyc]);
        checkOutput("miss_cnt", miss_cnt_o, exp_miss[cyc]);
        checkOutput("sat_trig_cnt", sat_trig_cnt, satv(exp_trig[cyc]));
        checkOutput("sat_miss_cnt", sat_miss_cnt, satv(exp_miss[cyc]));
      end
    end
  end

  initial begin : stimulus
    bit lvl;
    rstn_i     = 1'b0;
    enable_i   = 1'b0;
    ext_trig_i = 1'b0;
    cnt_clr_i  = 1'b0;
    delay_i    = '0;
    holdoff_i  = '0;
    en_v  = 1'b1;
    dly_v = 10;
    hld_v = 5;
    modelReset();

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkResetOutputs("reset");
    idle(5);

    $display("[TB] single trigger, delay 10, holdoff 5");
    clearCounters();
    pulse(3);
    idle(40);
    checkOutput("single_trig_cnt", trig_cnt_o, 1);
    checkOutput("single_miss_cnt", miss_cnt_o, 0);

    $display("[TB] delay 0 and 1 with holdoff 0");
    dly_v = 0; hld_v = 0;
    pulse(2); idle(20);
    dly_v = 1;
    pulse(2); idle(20);

    $display("[TB] triggers while busy");
    dly_v = 10; hld_v = 5;
    clearCounters();
    pulse(2); idle(4);
    pulse(2); idle(7);
    pulse(2); idle(3);
    pulse(2); idle(40);
    checkOutput("busy_trig_cnt", trig_cnt_o, 2);
    checkOutput("busy_miss_cnt", miss_cnt_o, 2);

    $display("[TB] disabled triggers and enable drop");
    clearCounters();
    en_v = 1'b0;
    repeat (4) begin
      pulse(2); idle(3);
    end
    idle(5);
    checkOutput("disabled_miss_cnt", miss_cnt_o, 4);
    checkOutput("disabled_trig_cnt", trig_cnt_o, 0);
    en_v = 1'b1;
    pulse(2); idle(6);
    en_v = 1'b0;
    idle(30);
    en_v = 1'b1;
    idle(5);

    $display("[TB] delay change mid-sequence and coincident clear");
    dly_v = 10;
    pulse(2); idle(8);
    dly_v = 3;
    idle(30);
    pulse(2); idle(30);
    pulse(2); idle(2);
    clearCounters();
    idle(1);
    checkOutput("coincident_clr_trig_cnt", trig_cnt_o, 0);
    idle(30);

    $display("[TB] reset during wait");
    dly_v = 10; hld_v = 5;
    pulse(2); idle(6);
    pulseReset();
    idle(30);
    checkOutput("post_reset_trig_cnt", trig_cnt_o, 0);

    $display("[TB] randomized trigger stream");
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        en_v  = ($urandom_range(0, 9) != 0);
        dly_v = $urandom_range(0, 12);
        hld_v = $urandom_range(0, 8);
      end
      if ($urandom_range(0, 5) == 0) lvl = ~lvl;
      applyStimulus(lvl, $urandom_range(0, 199) == 0, 1'b1);
    end
    lvl = 1'b0;
    en_v = 1'b1;
    idle(60);
    checkOutput("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pnr_trigger_sequencer.md
Name: pnr_trigger_sequencer

Overview:
Sequences the photon-number-resolving (PNR) comparator datapath from an external detector trigger. For each accepted trigger it issues a one-cycle clear strobe that resets the comparator, waits a programmable delay, then issues a one-cycle latch strobe that captures the photon-number segment. It then enforces a programmable holdoff and keeps accepted-trigger and missed-trigger statistics for readout by the register bank. It sits between the trigger input/GPIO and the PNR core, in the ADC clock domain.

Parameters:
DLY_W, 16, width of delay_i and holdoff_i
CNT_W, 32, width of trig_cnt_o and miss_cnt_o

Ports:
ADC_CLK  input  1  ADC sample clock; the only clock
rstn_i  input  1  asynchronous active-low reset
enable_i  input  1  arms the sequencer; level-sensitive
ext_trig_i  input  1  external trigger; asynchronous to ADC_CLK
delay_i  input  DLY_W  cycles from clear strobe to latch strobe
holdoff_i  input  DLY_W  dead cycles after the latch strobe
cnt_clr_i  input  1  synchronous clear of both counters
clear_o  output  1  one-cycle clear strobe to the PNR core (its trigger input)
latch_o  output  1  one-cycle latch strobe to the PNR core (its delayed_trigger input)
result_valid_o  output  1  one-cycle pulse, 2 cycles after latch_o; PNR result is stable
busy_o  output  1  high in every state except IDLE
state_o  output  3  current FSM state encoding, for debug readout
trig_cnt_o  output  CNT_W  accepted triggers
miss_cnt_o  output  CNT_W  triggers rejected because the sequencer was busy or disabled

Behaviour:
- Clocking and reset: one clock, ADC_CLK. rstn_i is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, synchronizer flops 0.
- Trigger input: ext_trig_i passes through a 2-flop synchronizer and a third edge-detect flop. rise = sync2 & ~prev. Only rising edges count; a level held high produces one event.
- FSM encoding: IDLE=0, CLEAR=1, WAIT=2, LATCH=3, HOLD=4, POST=5.
- IDLE:
  - rise & enable_i -> CLEAR. delay_i and holdoff_i are latched into internal registers at this transition.
  - rise & ~enable_i -> stay in IDLE; miss_cnt increments.
- CLEAR: clear_o=1 for exactly this cycle; trig_cnt increments. -> WAIT, with the counter loaded to max(delay_i,1)-1.
- WAIT: the counter decrements each cycle. When it reaches 0 -> LATCH. latch_o therefore rises exactly max(delay_i,1) cycles after clear_o rises.
- LATCH: latch_o=1 for exactly one cycle. -> POST, with a 2-cycle counter.
- POST: result_valid_o=1 on the second POST cycle, i.e. 2 cycles after latch_o. -> HOLD, with the counter loaded to holdoff_i.
- HOLD: the counter decrements each cycle; at 0 -> IDLE. holdoff_i=0 passes through HOLD in one cycle.
- Trigger latency: clear_o rises on the 4th ADC_CLK edge after the first edge that samples ext_trig_i high (2 sync edges, 1 detect edge, 1 FSM edge).
- Triggers while busy: any rise seen in a state other than IDLE increments miss_cnt; the sequence is unaffected.
- Shadowed config: changing delay_i or holdoff_i mid-sequence has no effect until the next accepted trigger.
- enable_i deasserted mid-sequence: the current sequence completes normally; no new triggers are accepted.
- Counters: both saturate at all-ones (no wrap).
- cnt_clr_i:
  - Zeroes both counters on the next edge.
  - It has priority over a same-cycle increment; that increment is lost.
  - It does not affect the FSM.
- Reset mid-sequence: returns immediately to IDLE with strobes low. No partial strobe is allowed to extend past reset assertion.
- Strobe exclusivity: clear_o and latch_o are never high in the same cycle; each is high for exactly one cycle per accepted trigger.
- Output timing: all outputs are registered, or decoded from registered state only, so there are no combinational paths from any input to any output.

Test Plan:
- Reset, enable_i=1, delay_i=10, holdoff_i=5, one 3-cycle ext_trig_i pulse -> clear_o one cycle at edge 4 after the sample; latch_o exactly 10 cycles after clear_o; result_valid_o 2 cycles after latch_o; busy_o low 8 cycles after latch_o (2 POST cycles, 6 HOLD cycles); trig_cnt=1, miss_cnt=0.
- delay_i=0 and delay_i=1 -> latch_o exactly 1 cycle after clear_o in both cases; holdoff_i=0 -> back in IDLE 3 cycles after latch_o.
- Second ext_trig_i edge during WAIT, and a third during HOLD -> no extra strobes; miss_cnt=2, trig_cnt=1. A trigger 1 cycle after return to IDLE is accepted (trig_cnt=2).
- enable_i=0 with 4 trigger edges -> no strobes, miss_cnt=4. enable_i dropped during WAIT -> latch_o still issued and the sequence completes.
- Change delay_i from 10 to 3 during WAIT -> the current latch stays at 10 cycles; the next trigger gives 3 cycles. cnt_clr_i coincident with CLEAR -> trig_cnt=0.
- rstn_i low for 1 cycle during WAIT -> all outputs 0 asynchronously, state_o=0, no latch_o afterwards. Preload counters near saturation (force) -> they hold at all-ones.
